// File: rtl/controle_elevador_pkg.sv
// controle_elevador_pkg: cabin FSM states and timer width shared by the elevator controller.
package controle_elevador_pkg;
  typedef enum logic [1:0] {PARADO, SUBINDO, DESCENDO, PORTA_ABERTA} estado_t;
  localparam int TIMER_W = 27;
endpackage

// File: rtl/controle_elevador_temporizador.sv
// temporizador: loadable down-counter with enable; fim_o pulses on the last counted cycle.
module temporizador
  import controle_elevador_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] valor_i,
  input  logic               en_i,
  output logic               fim_o
);
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? valor_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign fim_o = en_i && cnt_q == TIMER_W'(1);
endmodule

// File: rtl/controle_elevador.sv
// controle_elevador: SCAN-like elevator controller with latched floor requests.
// Define PARADA_EMERGENCIA_EN to add the emergencia input that freezes the cabin.
module controle_elevador
  import controle_elevador_pkg::*;
#(
  parameter int N_ANDARES   = 4,
  parameter int TEMPO_ANDAR = 50000000,
  parameter int TEMPO_PORTA = 100000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_ANDARES-1:0]         botoes,
`ifdef PARADA_EMERGENCIA_EN
  input  logic                         emergencia,
`endif
  output logic                         subindo,
  output logic                         descendo,
  output logic [$clog2(N_ANDARES)-1:0] andar_atual,
  output logic                         porta_aberta,
  output logic [N_ANDARES-1:0]         pedidos
);
  localparam int AW = $clog2(N_ANDARES);
  localparam logic [TIMER_W-1:0] T_ANDAR = TIMER_W'(TEMPO_ANDAR);
  localparam logic [TIMER_W-1:0] T_PORTA = TIMER_W'(TEMPO_PORTA);
  estado_t estado_q, estado_d;
  logic [AW-1:0] andar_q, andar_d, prox;
  logic [N_ANDARES-1:0] pedidos_q, pedidos_d, limpa, ignora;
  logic [TIMER_W-1:0] valor;
  logic carga, fim, em, movendo, acima, abaixo, alem_sub, alem_des, alem, ha_espaco;
`ifdef PARADA_EMERGENCIA_EN
  assign em = emergencia;
`else
  assign em = 1'b0;
`endif
  assign movendo   = estado_q == SUBINDO || estado_q == DESCENDO;
  assign prox      = estado_q == SUBINDO ? andar_q + 1'b1 : andar_q - 1'b1;
  assign alem      = estado_q == SUBINDO ? alem_sub : alem_des;
  assign ha_espaco = estado_q == SUBINDO ? andar_q != AW'(N_ANDARES - 1) : andar_q != '0;
  always_comb begin
    acima    = 1'b0;
    abaixo   = 1'b0;
    alem_sub = 1'b0;
    alem_des = 1'b0;
    for (int i = 0; i < N_ANDARES; i++) begin
      acima    = acima    | (pedidos_q[i] & (i > int'(andar_q)));
      abaixo   = abaixo   | (pedidos_q[i] & (i < int'(andar_q)));
      alem_sub = alem_sub | (pedidos_q[i] & (i > int'(andar_q) + 1));
      alem_des = alem_des | (pedidos_q[i] & (i < int'(andar_q) - 1));
    end
  end
  temporizador u_tmr (
    .clk     (clk),
    .rst     (reset),
    .load_i  (carga),
    .valor_i (valor),
    .en_i    (!em && estado_q != PARADO),
    .fim_o   (fim)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      estado_q  <= PARADO;
      andar_q   <= '0;
      pedidos_q <= '0;
    end else begin
      estado_q  <= estado_d;
      andar_q   <= andar_d;
      pedidos_q <= pedidos_d;
    end
  always_comb begin
    estado_d = estado_q;
    andar_d  = andar_q;
    limpa    = '0;
    carga    = 1'b0;
    valor    = T_ANDAR;
    if (!em)
      case (estado_q)
        PARADO:
          if (pedidos_q[andar_q]) begin
            estado_d       = PORTA_ABERTA;
            limpa[andar_q] = 1'b1;
            carga          = 1'b1;
            valor          = T_PORTA;
          end else if (acima || abaixo) begin
            estado_d = acima ? SUBINDO : DESCENDO;
            carga    = 1'b1;
          end
        SUBINDO, DESCENDO:
          if (fim && !ha_espaco) estado_d = PARADO;
          else if (fim) begin
            andar_d = prox;
            if (pedidos_q[prox]) begin
              estado_d    = PORTA_ABERTA;
              limpa[prox] = 1'b1;
              carga       = 1'b1;
              valor       = T_PORTA;
            end else if (alem) carga = 1'b1;
            else estado_d = PARADO;
          end
        PORTA_ABERTA:
          if (botoes[andar_q]) begin
            carga = 1'b1;
            valor = T_PORTA;
          end else if (fim) estado_d = PARADO;
        default: estado_d = PARADO;
      endcase
  end
  // the floor being served never latches its own button while the door is open
  assign ignora    = estado_q == PORTA_ABERTA ? N_ANDARES'(1) << andar_q : '0;
  assign pedidos_d = (pedidos_q | (botoes & ~ignora)) & ~limpa;
  always_comb begin
    subindo      = estado_q == SUBINDO && !em && movendo;
    descendo     = estado_q == DESCENDO && !em && movendo;
    porta_aberta = estado_q == PORTA_ABERTA;
    andar_atual  = andar_q;
    pedidos      = pedidos_q;
  end
endmodule

// File: tb/tb_controle_elevador.sv
// tb_controle_elevador: directed scenarios with N_ANDARES=4, TEMPO_ANDAR=4, TEMPO_PORTA=3.
module tb_controle_elevador;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] botoes = '0;
  logic       subindo, descendo, porta_aberta;
  logic [1:0] andar_atual;
  logic [3:0] pedidos;
  int n_cmp = 0;
  int n_err = 0;
  controle_elevador #(.N_ANDARES(4), .TEMPO_ANDAR(4), .TEMPO_PORTA(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .botoes       (botoes),
`ifdef PARADA_EMERGENCIA_EN
    .emergencia   (1'b0),
`endif
    .subindo      (subindo),
    .descendo     (descendo),
    .andar_atual  (andar_atual),
    .porta_aberta (porta_aberta),
    .pedidos      (pedidos)
  );
  always #5 clk = ~clk;
  task automatic espera(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    espera(2);
    reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      espera(1);
      n_cmp++;
      if ({subindo, descendo, porta_aberta, andar_atual, pedidos} !== 9'b0) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: got sub=%b des=%b porta=%b andar=%0d ped=%b, want all 0", k, subindo, descendo, porta_aberta, andar_atual, pedidos);
      end
    end
  endtask
  task automatic test_sobe;
    botoes = 4'b1000;
    espera(1);
    botoes = 4'b0000;
    n_cmp++;
    if (pedidos !== 4'b1000 || subindo !== 1'b0) begin
      n_err++;
      $display("FAIL sobe_latch: got ped=%b sub=%b, want ped=1000 sub=0", pedidos, subindo);
    end
    for (int k = 0; k < 12; k++) begin
      espera(1);
      n_cmp++;
      if (subindo !== 1'b1 || descendo !== 1'b0 || andar_atual !== 2'(k / 4)) begin
        n_err++;
        $display("FAIL sobe_travel cycle %0d: got sub=%b des=%b andar=%0d, want sub=1 des=0 andar=%0d", k, subindo, descendo, andar_atual, k / 4);
      end
    end
    for (int k = 0; k < 3; k++) begin
      espera(1);
      n_cmp++;
      if (porta_aberta !== 1'b1 || andar_atual !== 2'd3 || pedidos !== 4'b0 || subindo !== 1'b0) begin
        n_err++;
        $display("FAIL sobe_porta cycle %0d: got porta=%b andar=%0d ped=%b sub=%b, want 1/3/0000/0", k, porta_aberta, andar_atual, pedidos, subindo);
      end
    end
    espera(1);
    n_cmp++;
    if ({subindo, descendo, porta_aberta} !== 3'b000 || andar_atual !== 2'd3) begin
      n_err++;
      $display("FAIL sobe_parado: got sub=%b des=%b porta=%b andar=%0d, want 0/0/0/3", subindo, descendo, porta_aberta, andar_atual);
    end
  endtask
  task automatic test_desce;
    botoes = 4'b0001;
    espera(1);
    botoes = 4'b0000;
    n_cmp++;
    if (pedidos !== 4'b0001 || descendo !== 1'b0) begin
      n_err++;
      $display("FAIL desce_latch: got ped=%b des=%b, want ped=0001 des=0", pedidos, descendo);
    end
    for (int k = 0; k < 12; k++) begin
      espera(1);
      n_cmp++;
      if (descendo !== 1'b1 || subindo !== 1'b0 || andar_atual !== 2'(3 - k / 4)) begin
        n_err++;
        $display("FAIL desce_travel cycle %0d: got sub=%b des=%b andar=%0d, want sub=0 des=1 andar=%0d", k, subindo, descendo, andar_atual, 3 - k / 4);
      end
    end
    for (int k = 0; k < 3; k++) begin
      espera(1);
      n_cmp++;
      if (porta_aberta !== 1'b1 || andar_atual !== 2'd0 || pedidos !== 4'b0 || subindo !== 1'b0) begin
        n_err++;
        $display("FAIL desce_porta cycle %0d: got porta=%b andar=%0d ped=%b sub=%b, want 1/0/0000/0", k, porta_aberta, andar_atual, pedidos, subindo);
      end
    end
    espera(3);
    n_cmp++;
    if ({subindo, descendo, porta_aberta} !== 3'b000 || andar_atual !== 2'd0) begin
      n_err++;
      $display("FAIL desce_saturado: got sub=%b des=%b porta=%b andar=%0d, want 0/0/0/0", subindo, descendo, porta_aberta, andar_atual);
    end
  endtask
  task automatic test_parada_intermediaria;
    botoes = 4'b1000;
    espera(1);
    botoes = 4'b0000;
    espera(1);
    botoes = 4'b0100;
    espera(1);
    botoes = 4'b0000;
    n_cmp++;
    if (pedidos !== 4'b1100 || subindo !== 1'b1 || andar_atual !== 2'd0) begin
      n_err++;
      $display("FAIL inter_latch: got ped=%b sub=%b andar=%0d, want 1100/1/0", pedidos, subindo, andar_atual);
    end
    espera(7);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (porta_aberta !== 1'b1 || andar_atual !== 2'd2 || pedidos !== 4'b1000) begin
        n_err++;
        $display("FAIL inter_porta2 cycle %0d: got porta=%b andar=%0d ped=%b, want 1/2/1000", k, porta_aberta, andar_atual, pedidos);
      end
      espera(1);
    end
    n_cmp++;
    if ({subindo, porta_aberta} !== 2'b00 || andar_atual !== 2'd2) begin
      n_err++;
      $display("FAIL inter_parado: got sub=%b porta=%b andar=%0d, want 0/0/2", subindo, porta_aberta, andar_atual);
    end
    espera(1);
    n_cmp++;
    if (subindo !== 1'b1 || andar_atual !== 2'd2) begin
      n_err++;
      $display("FAIL inter_retoma: got sub=%b andar=%0d, want 1/2", subindo, andar_atual);
    end
    espera(4);
    n_cmp++;
    if (porta_aberta !== 1'b1 || andar_atual !== 2'd3 || pedidos !== 4'b0) begin
      n_err++;
      $display("FAIL inter_porta3: got porta=%b andar=%0d ped=%b, want 1/3/0000", porta_aberta, andar_atual, pedidos);
    end
    espera(3);
  endtask
  task automatic test_porta_reabre;
    botoes = 4'b0010;
    espera(1);
    botoes = 4'b0000;
    espera(9);
    n_cmp++;
    if (porta_aberta !== 1'b1 || andar_atual !== 2'd1) begin
      n_err++;
      $display("FAIL reabre_chegada: got porta=%b andar=%0d, want 1/1", porta_aberta, andar_atual);
    end
    for (int k = 0; k < 5; k++) begin
      botoes = 4'b0010;
      espera(1);
      botoes = 4'b0000;
      for (int j = 0; j < 2; j++) begin
        n_cmp++;
        if (porta_aberta !== 1'b1 || pedidos[1] !== 1'b0) begin
          n_err++;
          $display("FAIL reabre_press %0d.%0d: got porta=%b ped=%b, want porta=1 ped[1]=0", k, j, porta_aberta, pedidos);
        end
        espera(1);
      end
    end
    n_cmp++;
    if (porta_aberta !== 1'b1) begin
      n_err++;
      $display("FAIL reabre_ultimo: got porta=%b, want 1", porta_aberta);
    end
    espera(1);
    n_cmp++;
    if ({subindo, descendo, porta_aberta} !== 3'b000 || pedidos !== 4'b0 || andar_atual !== 2'd1) begin
      n_err++;
      $display("FAIL reabre_fecha: got sub=%b des=%b porta=%b ped=%b andar=%0d, want 0/0/0/0000/1", subindo, descendo, porta_aberta, pedidos, andar_atual);
    end
  endtask
  task automatic test_reset_meio;
    botoes = 4'b1000;
    espera(1);
    botoes = 4'b0000;
    espera(6);
    n_cmp++;
    if (subindo !== 1'b1 || andar_atual !== 2'd2 || pedidos !== 4'b1000) begin
      n_err++;
      $display("FAIL meio_pre: got sub=%b andar=%0d ped=%b, want 1/2/1000", subindo, andar_atual, pedidos);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({subindo, descendo, porta_aberta, andar_atual, pedidos} !== 9'b0) begin
      n_err++;
      $display("FAIL meio_async: got sub=%b des=%b porta=%b andar=%0d ped=%b, want all 0", subindo, descendo, porta_aberta, andar_atual, pedidos);
    end
    espera(1);
    reset = 1'b0;
    espera(6);
    n_cmp++;
    if ({subindo, descendo, porta_aberta, andar_atual, pedidos} !== 9'b0) begin
      n_err++;
      $display("FAIL meio_pos: got sub=%b des=%b porta=%b andar=%0d ped=%b, want all 0", subindo, descendo, porta_aberta, andar_atual, pedidos);
    end
  endtask
  initial begin
    test_reset;
    test_sobe;
    test_desce;
    test_parada_intermediaria;
    test_porta_reabre;
    test_reset_meio;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
